stride_line_gather: RTL and testbench
=====================================

# stride_line_gather

Receive-side counterpart of the strided line-transaction generator. Consumes aligned cache lines returned in ascending span order (aligned start through aligned end of a strided request) and extracts the strided elements from them, including elements misaligned across a line boundary. Emits a dense element stream with per-element index and last flag. Sits between the L1/line-return path and the load-writeback packer.

## Interface
- ADDR_W, 64, address width
- COUNT_W, 16, element-count width
- CL_BYTES, 128, line size in bytes (power of 2)
- MAX_EB, 8, maximum element bytes
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- start  in  1  request strobe, sampled only when busy=0
- base_addr  in  ADDR_W  address of element 0
- stride  in  ADDR_W  byte stride between elements
- elem_bytes  in  4  element size: 1, 2, 4 or 8
- elem_count  in  COUNT_W  N
- busy  out  1  request in progress
- line_valid  in  1  returned line present
- line_ready  out  1  block accepts a line
- line_addr  in  ADDR_W  line-aligned address
- line_data  in  CL_BYTES*8  line bytes, byte 0 in bits [7:0]
- line_last  in  1  final line of the request
- elem_valid  out  1  element present
- elem_ready  in  1  consumer accepts element
- elem_data  out  MAX_EB*8  element, lowest address in bits [7:0], unused upper bytes zero
- elem_idx  out  COUNT_W  element index 0..N-1
- elem_last  out  1  elem_idx == N-1
- err  out  1  sticky error, cleared by next accepted start or rst

## Operation
- States: IDLE, WAIT_LINE, EXTRACT.
- IDLE: busy=0, line_ready=0. On start: if elem_count==0, no-op (stay IDLE, err cleared). If elem_bytes not in {1,2,4,8} or stride < elem_bytes: err=1, stay IDLE. Otherwise err=0, busy=1, e=base_addr, idx=0, exp_line=base_addr & ~(CL_BYTES-1), partial=0 -> WAIT_LINE.
- WAIT_LINE: line_ready=1. On handshake: if line_addr != exp_line -> err=1, -> IDLE. Else capture line into buffer, -> EXTRACT.
- EXTRACT (line_ready=0), with off = e - exp_line (ADDR_W, modulo 2^ADDR_W):
  - partial=1: element completes from bytes 0.. of new line, merged above held low bytes; emit.
  - off >= CL_BYTES: line exhausted; if line_last=1 -> err, IDLE; else exp_line += CL_BYTES -> WAIT_LINE.
  - off + elem_bytes <= CL_BYTES: emit element bytes [off, off+elem_bytes).
  - otherwise (straddle): hold bytes [off, CL_BYTES) as low bytes, partial=1; if line_last=1 -> err, IDLE; else exp_line += CL_BYTES -> WAIT_LINE.
- Emit accepted (elem_valid & elem_ready): idx++, e += stride, partial=0. If accepted element had elem_last=1: if held line has line_last=0 -> err=1; either way -> IDLE, busy=0.
- Lines containing no element (stride > CL_BYTES) are consumed with no output.
- start while busy ignored.

## Timing
- Reset values: busy=0, line_ready=0, line buffer don't-care, elem_valid=0, elem_data=0, elem_idx=0, elem_last=0, err=0, partial=0. rst mid-operation discards held line and partial, drops any pending element, returns to IDLE next cycle.
- line_ready is a registered state decode; line handshake at edge k -> first elem_valid high after edge k+1.
- elem_valid/elem_data/elem_idx/elem_last registered; held stable while elem_valid=1 and elem_ready=0.
- Throughput: one element per cycle within a line with elem_ready=1 (next element loaded on the accepting edge).
- Line exhausted with no pending element: one cycle in EXTRACT, then line_ready high next cycle.
- busy falls on the edge that accepts the last element; start accepted the following cycle.

## Test plan
- base 0x1000, stride 4, eb 4, N 64, lines 0x1000 (last=0), 0x1080 (last=1), elem_ready=1 -> 64 elements back-to-back, idx 0..63, elem_data = line dwords in order, elem_last only on idx 63, err=0.
- Straddle: base 0x107E, stride 8, eb 4, N 2; lines 0x1000, 0x1080 (last) -> elem0 = {line1 bytes 1,0, line0 bytes 127,126}, elem1 = line1 bytes 6..9, err=0.
- base 0, stride 256, eb 8, N 3, lines 0x0..0x200 (5 lines) -> elements from lines 0x0, 0x100, 0x200 only; lines 0x80, 0x180 consumed silently; last on idx 2.
- Backpressure: case 1 with elem_ready random 50% -> identical sequence, data stable while stalled, line_ready=0 throughout EXTRACT.
- Errors: line_addr 0x1080 when 0x1000 expected -> err=1, busy=0; start with stride 2, eb 4 -> err=1, busy stays 0; eb 3 -> err=1.
- rst asserted mid-straddle (partial held) -> next cycle all outputs at reset values; new start then runs case 1 cleanly.

Source files
------------

// File: rtl/stride_line_gather.sv
// Receive-side strided gather: consumes ascending aligned lines of a strided
// request and emits a dense, indexed element stream, merging line-straddling elements.
module stride_line_gather #(
  parameter int ADDR_W   = 64,
  parameter int COUNT_W  = 16,
  parameter int CL_BYTES = 128,
  parameter int MAX_EB   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_W-1:0]     base_addr,
  input  logic [ADDR_W-1:0]     stride,
  input  logic [3:0]            elem_bytes,
  input  logic [COUNT_W-1:0]    elem_count,
  output logic                  busy,
  input  logic                  line_valid,
  output logic                  line_ready,
  input  logic [ADDR_W-1:0]     line_addr,
  input  logic [CL_BYTES*8-1:0] line_data,
  input  logic                  line_last,
  output logic                  elem_valid,
  input  logic                  elem_ready,
  output logic [MAX_EB*8-1:0]   elem_data,
  output logic [COUNT_W-1:0]    elem_idx,
  output logic                  elem_last,
  output logic                  err
);
  localparam int OFF_W = $clog2(CL_BYTES);
  localparam int HC_W  = $clog2(MAX_EB);
  localparam int EW    = MAX_EB * 8;
  localparam logic [1:0] S_IDLE = 2'd0, S_WAIT = 2'd1, S_EXTR = 2'd2;

  logic [1:0]            state;
  logic [ADDR_W-1:0]     e, exp_line, stride_r;
  logic [3:0]            eb_r;
  logic [COUNT_W-1:0]    cnt, n_r;
  logic                  partial;
  logic [EW-1:0]         hold;
  logic [HC_W-1:0]       hold_cnt;
  logic [CL_BYTES*8-1:0] buf_data;
  logic                  buf_last;

  logic [ADDR_W-1:0]     off;
  logic [CL_BYTES*8-1:0] shifted;
  logic [EW-1:0]         win, merged, mask;
  logic                  exhausted, fits, eb_ok, accept, can_load;

  assign busy       = (state != S_IDLE);
  assign line_ready = (state == S_WAIT);

  // off wraps modulo 2^ADDR_W; while partial it is meaningless and ignored
  assign off       = e - exp_line;
  assign exhausted = off >= ADDR_W'(CL_BYTES);
  assign fits      = ({1'b0, off[OFF_W-1:0]} + (OFF_W+1)'(eb_r)) <= (OFF_W+1)'(CL_BYTES);
  assign shifted   = buf_data >> {off[OFF_W-1:0], 3'b000};
  assign win       = shifted[EW-1:0];
  assign merged    = hold | (buf_data[EW-1:0] << {hold_cnt, 3'b000});
  assign mask      = ~({EW{1'b1}} << {eb_r, 3'b000});
  assign eb_ok     = (elem_bytes == 4'd1) || (elem_bytes == 4'd2) ||
                     (elem_bytes == 4'd4) || (elem_bytes == 4'd8);
  assign accept    = elem_valid & elem_ready;
  assign can_load  = ~elem_valid | elem_ready;

  always_ff @(posedge clk)
    if (state == S_WAIT && line_valid) begin
      buf_data <= line_data;
      buf_last <= line_last;
    end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      partial    <= 1'b0;
      elem_valid <= 1'b0;
      elem_data  <= '0;
      elem_idx   <= '0;
      elem_last  <= 1'b0;
      err        <= 1'b0;
      e          <= '0;
      exp_line   <= '0;
      stride_r   <= '0;
      eb_r       <= '0;
      cnt        <= '0;
      n_r        <= '0;
      hold       <= '0;
      hold_cnt   <= '0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          if (elem_count == '0) err <= 1'b0;
          else if (!eb_ok || stride < ADDR_W'(elem_bytes)) err <= 1'b1;
          else begin
            err      <= 1'b0;
            state    <= S_WAIT;
            e        <= base_addr;
            cnt      <= '0;
            exp_line <= base_addr & ~ADDR_W'(CL_BYTES - 1);
            partial  <= 1'b0;
            stride_r <= stride;
            eb_r     <= elem_bytes;
            n_r      <= elem_count;
          end
        end
        S_WAIT: if (line_valid) begin
          if (line_addr != exp_line) begin
            err   <= 1'b1;
            state <= S_IDLE;
          end else state <= S_EXTR;
        end
        S_EXTR: if (can_load) begin
          // element index/address advance when an element is loaded into the output slot
          elem_valid <= 1'b0;
          if (accept && elem_last) begin
            if (!buf_last) err <= 1'b1;
            state <= S_IDLE;
          end else if (partial || (!exhausted && fits)) begin
            elem_valid <= 1'b1;
            elem_data  <= (partial ? merged : win) & mask;
            elem_idx   <= cnt;
            elem_last  <= (cnt == n_r - 1'b1);
            cnt        <= cnt + 1'b1;
            e          <= e + stride_r;
            partial    <= 1'b0;
          end else begin
            if (!exhausted) begin
              hold     <= win;
              hold_cnt <= HC_W'(ADDR_W'(CL_BYTES) - off);
              partial  <= 1'b1;
            end
            if (buf_last) begin
              err   <= 1'b1;
              state <= S_IDLE;
            end else begin
              exp_line <= exp_line + ADDR_W'(CL_BYTES);
              state    <= S_WAIT;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_stride_line_gather.sv
// Directed bench for stride_line_gather: a table of requests served by a line
// driver/consumer loop, with an address-based byte model for expected elements.
module tb_stride_line_gather;
  logic           clk = 1'b0;
  logic           rst, start, line_valid, line_last, elem_ready;
  logic [63:0]    base_addr, stride, line_addr;
  logic [3:0]     elem_bytes;
  logic [15:0]    elem_count, elem_idx;
  logic [1023:0]  line_data;
  logic [63:0]    elem_data;
  logic           busy, line_ready, elem_valid, elem_last, err;

  stride_line_gather dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .stride(stride),
    .elem_bytes(elem_bytes), .elem_count(elem_count), .busy(busy),
    .line_valid(line_valid), .line_ready(line_ready), .line_addr(line_addr),
    .line_data(line_data), .line_last(line_last), .elem_valid(elem_valid),
    .elem_ready(elem_ready), .elem_data(elem_data), .elem_idx(elem_idx),
    .elem_last(elem_last), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] base, stride, line0;
    logic [3:0]  eb;
    logic [15:0] n;
    int          nl, exp_n, exp_lines;
    bit          bp, exp_err;
  } vec_t;

  vec_t tv[12];
  int nvec = 0, nmis = 0;

  function automatic logic [7:0] bval(input logic [63:0] a);
    logic [63:0] t;
    t = a ^ (a >> 7) ^ 64'h5A;
    return t[7:0];
  endfunction

  function automatic logic [1023:0] mkline(input logic [63:0] a);
    logic [1023:0] d;
    for (int j = 0; j < 128; j++) d[j*8 +: 8] = bval(a + 64'(j));
    return d;
  endfunction

  function automatic logic [63:0] exp_elem(input vec_t v, input int i);
    logic [63:0] d, a;
    d = '0;
    a = v.base + 64'(i) * v.stride;
    for (int j = 0; j < 8; j++) if (j < int'(v.eb)) d[j*8 +: 8] = bval(a + 64'(j));
    return d;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
    nvec++;
    if (act !== want) begin
      nmis++;
      $display("FAIL %s: got %h want %h", nm, act, want);
    end
  endtask

  task automatic run(input vec_t v, input int id);
    int k = 0, got = 0, cyc = 0;
    bit hs_l, pv = 0, pr = 0;
    logic [63:0] pd = '0;
    logic [15:0] pi = '0;
    @(negedge clk);
    start = 1'b1; base_addr = v.base; stride = v.stride; elem_bytes = v.eb; elem_count = v.n;
    @(negedge clk);
    start = 1'b0;
    while (busy && cyc < 4000) begin
      if (k < v.nl) begin
        line_valid = 1'b1;
        line_addr  = v.line0 + 64'(k) * 64'd128;
        line_data  = mkline(line_addr);
        line_last  = (k == v.nl - 1);
      end else line_valid = 1'b0;
      elem_ready = v.bp ? 1'($urandom_range(0, 1)) : 1'b1;
      if (pv && !pr) begin
        chk($sformatf("v%0d stall_valid", id), 64'(elem_valid), 64'd1);
        chk($sformatf("v%0d stall_data", id), elem_data, pd);
        chk($sformatf("v%0d stall_idx", id), 64'(elem_idx), 64'(pi));
      end
      if (elem_valid) begin
        chk($sformatf("v%0d line_ready_in_extract", id), 64'(line_ready), 64'd0);
        if (elem_ready) begin
          chk($sformatf("v%0d data[%0d]", id, got), elem_data, exp_elem(v, got));
          chk($sformatf("v%0d idx[%0d]", id, got), 64'(elem_idx), 64'(got));
          chk($sformatf("v%0d last[%0d]", id, got), 64'(elem_last), 64'(got == int'(v.n) - 1));
          got++;
        end
      end
      pv = elem_valid; pr = elem_ready; pd = elem_data; pi = elem_idx;
      hs_l = line_valid && line_ready;
      @(posedge clk);
      if (hs_l) k++;
      @(negedge clk);
      cyc++;
    end
    line_valid = 1'b0;
    elem_ready = 1'b1;
    if (cyc >= 4000) begin
      nvec++; nmis++;
      $display("FAIL v%0d timeout: still busy after %0d cycles, want idle", id, cyc);
    end
    chk($sformatf("v%0d err", id), 64'(err), 64'(v.exp_err));
    chk($sformatf("v%0d elem_count_out", id), 64'(got), 64'(v.exp_n));
    chk($sformatf("v%0d lines_taken", id), 64'(k), 64'(v.exp_lines));
    chk($sformatf("v%0d busy_end", id), 64'(busy), 64'd0);
  endtask

  initial begin
    //         base        stride     line0       eb    n       nl exp_n lines bp err
    tv[0]  = '{64'h1000,  64'd4,    64'h1000,  4'd4, 16'd64,  2, 64,   2,    0, 0};
    tv[1]  = '{64'h107E,  64'd8,    64'h1000,  4'd4, 16'd2,   2, 2,    2,    0, 0};
    tv[2]  = '{64'h0,     64'd256,  64'h0,     4'd8, 16'd3,   5, 3,    5,    0, 0};
    tv[3]  = '{64'h1000,  64'd4,    64'h1000,  4'd4, 16'd64,  2, 64,   2,    1, 0};
    tv[4]  = '{64'h1000,  64'd4,    64'h1080,  4'd4, 16'd64,  2, 0,    1,    0, 1};
    tv[5]  = '{64'h1000,  64'd2,    64'h1000,  4'd4, 16'd64,  2, 0,    0,    0, 1};
    tv[6]  = '{64'h1000,  64'd4,    64'h1000,  4'd4, 16'd0,   2, 0,    0,    0, 0};
    tv[7]  = '{64'h1000,  64'd4,    64'h1000,  4'd3, 16'd4,   2, 0,    0,    0, 1};
    tv[8]  = '{64'h2005,  64'd3,    64'h2000,  4'd1, 16'd100, 3, 100,  3,    0, 0};
    tv[9]  = '{64'h7F,    64'd130,  64'h0,     4'd2, 16'd3,   4, 3,    4,    1, 0};
    tv[10] = '{64'h1000,  64'd4,    64'h1000,  4'd4, 16'd64,  1, 32,   1,    0, 1};
    tv[11] = '{64'h1000,  64'd4,    64'h1000,  4'd4, 16'd4,   2, 4,    1,    0, 1};

    rst = 1'b1; start = 1'b0; line_valid = 1'b0; line_last = 1'b0; elem_ready = 1'b1;
    base_addr = '0; stride = '0; elem_bytes = '0; elem_count = '0; line_addr = '0; line_data = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset line_ready", 64'(line_ready), 64'd0);
    chk("reset elem_valid", 64'(elem_valid), 64'd0);
    chk("reset err", 64'(err), 64'd0);

    // straddle element: bytes 126,127 of line 0x1000 then bytes 0,1 of line 0x1080
    chk("straddle model", exp_elem(tv[1], 0),
        {32'h0, bval(64'h1081), bval(64'h1080), bval(64'h107F), bval(64'h107E)});

    for (int i = 0; i < 12; i++) run(tv[i], i);

    // reset while the low half of a straddling element is held
    @(negedge clk);
    start = 1'b1; base_addr = 64'h107E; stride = 64'd8; elem_bytes = 4'd4; elem_count = 16'd2;
    @(negedge clk);
    start = 1'b0;
    line_valid = 1'b1; line_addr = 64'h1000; line_data = mkline(64'h1000); line_last = 1'b0;
    chk("rstseq wait_line", 64'(line_ready), 64'd1);
    @(negedge clk);
    line_valid = 1'b0;
    chk("rstseq extract", 64'(line_ready), 64'd0);
    @(negedge clk);
    chk("rstseq straddle_wait", 64'(line_ready), 64'd1);
    chk("rstseq no_elem", 64'(elem_valid), 64'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rstseq busy", 64'(busy), 64'd0);
    chk("rstseq line_ready", 64'(line_ready), 64'd0);
    chk("rstseq elem_valid", 64'(elem_valid), 64'd0);
    chk("rstseq elem_data", elem_data, 64'd0);
    chk("rstseq elem_idx", 64'(elem_idx), 64'd0);
    chk("rstseq elem_last", 64'(elem_last), 64'd0);
    chk("rstseq err", 64'(err), 64'd0);
    run(tv[0], 100);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
